// File: rtl/ssm_scan_sequencer.sv
// rtl/ssm_scan_sequencer.sv - (h, p, t) scan sequencer for the SSM tile datapath
//
// Walks every (h, p) group of the SSM block, issuing TILES state tiles per
// group (t innermost, then p, then h). Addresses for the scalar, x, B/C and
// h_prev stores are presented while in FETCH so the 1-cycle SRAMs have data
// ready when the tile is offered in ISSUE. Each finished group's flat index
// h*P+p is queued so returning y results are tagged in order. The queue depth
// doubles as a credit limit on outstanding groups.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         begin a scan (sampled only while idle)
//   busy_o, done_o  scan in progress / one-cycle completion pulse
//   scal_addr_o     h            (dt, dt_bias, A, D)
//   x_addr_o        h*P+p        (x)
//   bc_addr_o       t            (B/C tile)
//   hprev_addr_o    (h*P+p)*TILES+t (h_prev tile word)
//   tile_valid_o / tile_ready_i   tile handshake with the SSM block
//   y_i, y_valid_i  result from the SSM block
//   y_o, y_idx_o, y_valid_o       registered result tagged with h*P+p
//   err_o           sticky: result arrived with no group outstanding
module ssm_scan_sequencer #(
  parameter int DW      = 16,
  parameter int H       = 24,
  parameter int P       = 64,
  parameter int N_TOTAL = 128,
  parameter int N_TILE  = 16,
  parameter int MAX_OUT = 8,
  localparam int TILES  = N_TOTAL / N_TILE,
  localparam int SW     = (H > 1) ? $clog2(H) : 1,
  localparam int IW     = (H * P > 1) ? $clog2(H * P) : 1,
  localparam int TW     = (TILES > 1) ? $clog2(TILES) : 1,
  localparam int AW     = (H * P * TILES > 1) ? $clog2(H * P * TILES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [SW-1:0] scal_addr_o,
  output logic [IW-1:0] x_addr_o,
  output logic [TW-1:0] bc_addr_o,
  output logic [AW-1:0] hprev_addr_o,
  output logic          tile_valid_o,
  input  logic          tile_ready_i,
  input  logic [DW-1:0] y_i,
  input  logic          y_valid_i,
  output logic [DW-1:0] y_o,
  output logic [IW-1:0] y_idx_o,
  output logic          y_valid_o,
  output logic          err_o
);

  localparam int PPW = (P > 1) ? $clog2(P) : 1;
  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Scan counters; they drive the address outputs directly, so they only
  // move on a tile transfer (entry into FETCH) and stay put through ISSUE.
  logic [SW-1:0]  h_q, h_d;
  logic [PPW-1:0] p_q, p_d;
  logic [TW-1:0]  t_q, t_d;
  logic [IW-1:0]  idx_q, idx_d;   // h*P+p kept incrementally
  logic [AW-1:0]  hw_q, hw_d;     // (h*P+p)*TILES+t kept incrementally

  logic start_q;
  logic busy_q, done_q, tile_valid_q;
  logic [DW-1:0] y_q;
  logic [IW-1:0] y_idx_q;
  logic y_valid_q, err_q;

  logic [IW-1:0] fifo_q [MAX_OUT];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  logic push, pop, pop_err, start_take;

  assign pop     = y_valid_i && (count_q != '0);
  assign pop_err = y_valid_i && (count_q == '0);

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    p_d        = p_q;
    t_d        = t_q;
    idx_d      = idx_q;
    hw_d       = hw_q;
    push       = 1'b0;
    start_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          start_take = 1'b1;
          state_d    = S_FETCH;
          h_d        = '0;
          p_d        = '0;
          t_d        = '0;
          idx_d      = '0;
          hw_d       = '0;
        end
      end
      S_FETCH: begin
        // A new group may only be offered while a result slot is free.
        if ((t_q != '0) || (count_q != CW'(MAX_OUT))) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tile_valid_q && tile_ready_i) begin
          if (t_q != TW'(TILES - 1)) begin
            t_d     = t_q + 1'b1;
            hw_d    = hw_q + 1'b1;
            state_d = S_FETCH;
          end else begin
            push = 1'b1;
            if (idx_q == IW'(H * P - 1)) begin
              // Final group: leave the addresses on the last tile.
              state_d = S_DRAIN;
            end else begin
              t_d   = '0;
              hw_d  = hw_q + 1'b1;
              idx_d = idx_q + 1'b1;
              if (p_q == PPW'(P - 1)) begin
                p_d = '0;
                h_d = h_q + 1'b1;
              end else begin
                p_d = p_q + 1'b1;
              end
              state_d = S_FETCH;
            end
          end
        end
      end
      S_DRAIN: begin
        if ((count_q == '0) && !y_valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      h_q          <= '0;
      p_q          <= '0;
      t_q          <= '0;
      idx_q        <= '0;
      hw_q         <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tile_valid_q <= 1'b0;
      y_q          <= '0;
      y_idx_q      <= '0;
      y_valid_q    <= 1'b0;
      err_q        <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      p_q          <= p_d;
      t_q          <= t_d;
      idx_q        <= idx_d;
      hw_q         <= hw_d;
      // start is registered once so address setup has a full cycle of slack.
      start_q      <= (state_q == S_IDLE) && !start_q && start_i;
      busy_q       <= (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_q       <= (state_d == S_DONE);
      tile_valid_q <= (state_d == S_ISSUE);
      y_valid_q    <= pop;
      if (pop) begin
        y_q     <= y_i;
        y_idx_q <= fifo_q[rd_q];
        rd_q    <= (rd_q == PW'(MAX_OUT - 1)) ? '0 : rd_q + 1'b1;
      end
      if (push) begin
        wr_q <= (wr_q == PW'(MAX_OUT - 1)) ? '0 : wr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (pop_err) begin
        err_q <= 1'b1;
      end else if (start_take) begin
        err_q <= 1'b0;
      end
    end
  end

  // Index storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_q] <= idx_q;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign tile_valid_o = tile_valid_q;
  assign scal_addr_o  = h_q;
  assign x_addr_o     = idx_q;
  assign bc_addr_o    = t_q;
  assign hprev_addr_o = hw_q;
  assign y_o          = y_q;
  assign y_idx_o      = y_idx_q;
  assign y_valid_o    = y_valid_q;
  assign err_o        = err_q;

endmodule
